// File: rtl/inst_rom_arb.sv
// inst_rom_arb: shares the instruction ROM read port between fetch (F) and debug/loader (D)
// Ports:
//   clk, rst                         clock, asynchronous active-low reset
//   f_req_* / d_req_*                valid/ready request channels with byte address
//   f_flush                          cancels every F-owned entry in flight
//   f_rsp_* / d_rsp_*                registered responses (inst, misalign err) with backpressure
//   rom_ce, rom_addr, rom_inst       combinational ROM read port
module inst_rom_arb #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int FETCH_PRIO = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req_valid,
    output logic              f_req_ready,
    input  logic [ADDR_W-1:0] f_req_addr,
    input  logic              f_flush,
    output logic              f_rsp_valid,
    input  logic              f_rsp_ready,
    output logic [DATA_W-1:0] f_rsp_inst,
    output logic              f_rsp_err,
    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic [ADDR_W-1:0] d_req_addr,
    output logic              d_rsp_valid,
    input  logic              d_rsp_ready,
    output logic [DATA_W-1:0] d_rsp_inst,
    output logic              d_rsp_err,
    output logic              rom_ce,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_inst
);
    localparam logic ID_F = 1'b0;
    localparam logic ID_D = 1'b1;

    logic              a_valid, a_id, a_err;
    logic [ADDR_W-1:0] a_addr;
    logic              b_valid, b_id, b_err;
    logic [DATA_W-1:0] b_inst;
    logic [3:0]        starve_cnt;
    logic              rr_d_last;
    logic              b_free, a_free, f_elig, d_elig, grant_f, grant_d, accept, a_move;
    logic [ADDR_W-1:0] acc_addr;

    always_comb begin
        b_free   = ~b_valid | (b_id == ID_D ? d_rsp_ready : f_rsp_ready);
        a_free   = ~a_valid | b_free;
        f_elig   = f_req_valid & ~f_flush;
        d_elig   = d_req_valid;
        // priority mode: D only wins when F is idle or D has starved long enough
        grant_d  = d_elig & (~f_elig | ((FETCH_PRIO != 0) ? (starve_cnt == 4'(STARVE_MAX)) : ~rr_d_last));
        grant_f  = f_elig & ~grant_d;
        // readies are gated by rst so every output is 0 while reset is held
        f_req_ready = rst & a_free & grant_f;
        d_req_ready = rst & a_free & grant_d;
        accept   = a_free & (grant_f | grant_d);
        acc_addr = grant_d ? d_req_addr : f_req_addr;
        a_move   = a_valid & b_free;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_valid    <= 1'b0;
            a_id       <= ID_F;
            a_err      <= 1'b0;
            a_addr     <= '0;
            b_valid    <= 1'b0;
            b_id       <= ID_F;
            b_err      <= 1'b0;
            b_inst     <= '0;
            starve_cnt <= '0;
            rr_d_last  <= 1'b1;
        end else begin
            a_valid <= accept | (a_valid & ~b_free & ~(f_flush & a_id == ID_F));
            if (accept) begin
                a_addr <= acc_addr;
                a_id   <= grant_d;
                a_err  <= |acc_addr[1:0];
            end
            // a flushed F entry moving A->B is dropped instead of landing in B
            if (a_move) begin
                b_valid <= ~(f_flush & a_id == ID_F);
                b_id    <= a_id;
                b_inst  <= a_err ? '0 : rom_inst;
                b_err   <= a_err;
            end else begin
                b_valid <= b_valid & ~b_free & ~(f_flush & b_id == ID_F);
            end
            if (accept) rr_d_last <= grant_d;
            if (FETCH_PRIO != 0 && a_free)
                starve_cnt <= grant_d ? 4'd0 :
                              (d_elig && starve_cnt != 4'(STARVE_MAX)) ? starve_cnt + 4'd1 : starve_cnt;
        end
    end

    always_comb begin
        rom_ce      = a_valid & ~a_err;
        rom_addr    = rom_ce ? a_addr : '0;
        f_rsp_valid = b_valid & (b_id == ID_F);
        d_rsp_valid = b_valid & (b_id == ID_D);
        f_rsp_inst  = f_rsp_valid ? b_inst : '0;
        d_rsp_inst  = d_rsp_valid ? b_inst : '0;
        f_rsp_err   = f_rsp_valid & b_err;
        d_rsp_err   = d_rsp_valid & b_err;
    end
endmodule

// File: tb/tb_inst_rom_arb.sv
// tb_inst_rom_arb: scoreboard bench for inst_rom_arb in priority and round-robin modes
module tb_inst_rom_arb;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        f_req_valid = 0, f_req_ready, f_flush = 0, f_rsp_valid, f_rsp_ready = 1, f_rsp_err;
    logic [31:0] f_req_addr = 0, f_rsp_inst;
    logic        d_req_valid = 0, d_req_ready, d_rsp_valid, d_rsp_ready = 1, d_rsp_err;
    logic [31:0] d_req_addr = 0, d_rsp_inst;
    logic        rom_ce;
    logic [31:0] rom_addr, rom_inst;

    logic        r_f_valid = 0, r_f_ready, r_f_rsp_valid, r_f_rsp_err;
    logic        r_d_valid = 0, r_d_ready, r_d_rsp_valid, r_d_rsp_err;
    logic [31:0] r_f_rsp_inst, r_d_rsp_inst, r_rom_addr, r_rom_inst;
    logic        r_rom_ce;

    logic [31:0] rom [64];
    initial begin
        for (int i = 0; i < 64; i++) rom[i] = {8'(i), 8'hA5, 8'(i * 7), 8'h13};
        rom[2] = 32'h0200_0193;
    end
    assign rom_inst   = rom_ce ? rom[rom_addr[7:2]] : '0;
    assign r_rom_inst = r_rom_ce ? rom[r_rom_addr[7:2]] : '0;

    inst_rom_arb #(.FETCH_PRIO(1), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .f_req_valid(f_req_valid), .f_req_ready(f_req_ready), .f_req_addr(f_req_addr), .f_flush(f_flush),
        .f_rsp_valid(f_rsp_valid), .f_rsp_ready(f_rsp_ready), .f_rsp_inst(f_rsp_inst), .f_rsp_err(f_rsp_err),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
        .d_rsp_valid(d_rsp_valid), .d_rsp_ready(d_rsp_ready), .d_rsp_inst(d_rsp_inst), .d_rsp_err(d_rsp_err),
        .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_inst(rom_inst)
    );

    inst_rom_arb #(.FETCH_PRIO(0)) dut_rr (
        .clk(clk), .rst(rst),
        .f_req_valid(r_f_valid), .f_req_ready(r_f_ready), .f_req_addr(32'h0), .f_flush(1'b0),
        .f_rsp_valid(r_f_rsp_valid), .f_rsp_ready(1'b1), .f_rsp_inst(r_f_rsp_inst), .f_rsp_err(r_f_rsp_err),
        .d_req_valid(r_d_valid), .d_req_ready(r_d_ready), .d_req_addr(32'h4),
        .d_rsp_valid(r_d_rsp_valid), .d_rsp_ready(1'b1), .d_rsp_inst(r_d_rsp_inst), .d_rsp_err(r_d_rsp_err),
        .rom_ce(r_rom_ce), .rom_addr(r_rom_addr), .rom_inst(r_rom_inst)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int f_got    = 0;
    logic [32:0] f_exp [$];
    logic [32:0] d_exp [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [32:0] exp_of(input logic [31:0] a);
        return (a[1:0] != 2'b00) ? {1'b1, 32'h0} : {1'b0, rom[a[7:2]]};
    endfunction

    // scoreboard: inputs change just after posedge, so negedge sees the settled cycle
    always @(negedge clk) if (rst) begin
        if (f_rsp_valid && f_rsp_ready) begin
            if (f_exp.size() == 0) check("f_unexpected", 1, 0);
            else check("f_rsp", {f_rsp_err, f_rsp_inst}, f_exp.pop_front());
            f_got++;
        end
        if (d_rsp_valid && d_rsp_ready) begin
            if (d_exp.size() == 0) check("d_unexpected", 1, 0);
            else check("d_rsp", {d_rsp_err, d_rsp_inst}, d_exp.pop_front());
        end
        if (f_flush) f_exp.delete();
        if (f_req_valid && f_req_ready) f_exp.push_back(exp_of(f_req_addr));
        if (d_req_valid && d_req_ready) d_exp.push_back(exp_of(d_req_addr));
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b0;
        f_req_valid = 0; d_req_valid = 0; f_flush = 0; f_rsp_ready = 1; d_rsp_ready = 1;
        f_exp.delete();
        d_exp.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    int base;

    initial begin
        do_reset();
        @(negedge clk);
        check("reset_rom_ce", rom_ce, 0);
        check("reset_f_rsp_valid", f_rsp_valid, 0);
        tick();

        f_req_valid = 1; f_req_addr = 32'h8;
        @(negedge clk); check("single_ready", f_req_ready, 1);
        tick(); f_req_valid = 0;
        @(negedge clk); check("single_rom_ce", rom_ce, 1); check("single_rom_addr", rom_addr, 32'h8);
        tick();
        @(negedge clk); check("single_rsp_valid", f_rsp_valid, 1); check("single_inst", f_rsp_inst, 32'h0200_0193);
        tick();
        @(negedge clk); check("single_rsp_once", f_rsp_valid, 0);

        do_reset();
        for (int i = 0; i < 10; i++) begin
            f_req_valid = 1; f_req_addr = 32'h40; d_req_valid = 1; d_req_addr = 32'(i * 4);
            @(negedge clk);
            check("prio_d_grant", d_req_ready, (i % 5) == 4);
            check("prio_f_grant", f_req_ready, (i % 5) != 4);
            tick();
        end
        f_req_valid = 0; d_req_valid = 0;
        repeat (3) tick();
        check("prio_f_drained", f_exp.size(), 0);
        check("prio_d_drained", d_exp.size(), 0);

        r_f_valid = 1; r_d_valid = 1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("rr_f_grant", r_f_ready, (i % 2) == 0);
            check("rr_d_grant", r_d_ready, (i % 2) == 1);
            tick();
        end
        r_f_valid = 0; r_d_valid = 0;

        do_reset();
        base = f_got;
        f_rsp_ready = 0; f_req_valid = 1; f_req_addr = 32'h0;
        @(negedge clk); check("bp_acc0", f_req_ready, 1);
        tick(); f_req_addr = 32'h4;
        @(negedge clk); check("bp_acc1", f_req_ready, 1);
        tick(); f_req_addr = 32'h8;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_hold_valid", f_rsp_valid, 1);
            check("bp_hold_inst", f_rsp_inst, rom[0]);
            check("bp_full_ready", f_req_ready, 0);
            tick();
        end
        f_rsp_ready = 1;
        @(negedge clk); check("bp_resume_ready", f_req_ready, 1);
        tick(); f_req_valid = 0;
        repeat (4) tick();
        check("bp_delivered", f_got - base, 3);
        check("bp_f_empty", f_exp.size(), 0);

        do_reset();
        base = f_got;
        f_rsp_ready = 0; f_req_valid = 1; f_req_addr = 32'h10;
        tick(); f_req_addr = 32'h14;
        tick(); f_req_valid = 0; f_flush = 1;
        tick(); f_flush = 0; f_rsp_ready = 1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); check("flush_f_gone", f_rsp_valid, 0);
            tick();
        end
        check("flush_no_f_rsp", f_got - base, 0);

        d_req_valid = 1; d_req_addr = 32'h24;
        @(negedge clk); check("flush_d_acc", d_req_ready, 1);
        tick(); d_req_valid = 0; f_req_valid = 1; f_req_addr = 32'h18;
        @(negedge clk); check("flush_f_acc", f_req_ready, 1);
        tick(); f_req_addr = 32'h1C; f_flush = 1;
        @(negedge clk);
        check("flush_no_grant", f_req_ready, 0);
        check("flush_d_kept", d_rsp_valid, 1);
        check("flush_d_inst", d_rsp_inst, rom[9]);
        tick(); f_flush = 0; f_req_valid = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); check("flush_f_vanish", f_rsp_valid, 0);
            tick();
        end

        d_req_valid = 1; d_req_addr = 32'h6;
        @(negedge clk); check("mis_acc", d_req_ready, 1);
        tick(); d_req_valid = 0;
        @(negedge clk); check("mis_no_ce", rom_ce, 0);
        tick();
        @(negedge clk);
        check("mis_valid", d_rsp_valid, 1);
        check("mis_err", d_rsp_err, 1);
        check("mis_inst", d_rsp_inst, 0);
        tick();

        f_req_valid = 1; f_req_addr = 32'h0;
        tick(); f_req_addr = 32'h4;
        tick(); f_req_addr = 32'h8;
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("rst_f_rsp_valid", f_rsp_valid, 0);
        check("rst_rom_ce", rom_ce, 0);
        check("rst_f_ready", f_req_ready, 0);
        f_req_valid = 0;
        f_exp.delete();
        d_exp.delete();
        @(posedge clk);
        #1 rst = 1'b1;
        f_req_valid = 1; f_req_addr = 32'hC;
        @(negedge clk); check("post_rst_acc", f_req_ready, 1);
        tick(); f_req_valid = 0;
        tick();
        @(negedge clk);
        check("post_rst_valid", f_rsp_valid, 1);
        check("post_rst_inst", f_rsp_inst, rom[3]);
        repeat (2) tick();
        check("final_f_empty", f_exp.size(), 0);
        check("final_d_empty", d_exp.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
